sr_latch: RTL and testbench

SR_LATCH -- requirements
Module: sr_latch

---
 rtl/sr_latch_pkg.sv | 33 +++
 rtl/sr_sync.sv | 29 ++
 rtl/sr_latch.sv | 86 ++++++++
 tb/tb_sr_latch.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_latch_pkg.sv
// Shared types and reset values for the clocked SR latch and its input synchronizers.
package sr_latch_pkg;

  // What the latch does when both active-low requests are asserted together.
  typedef enum logic [1:0] {
    POL_HOLD  = 2'd0,
    POL_SET   = 2'd1,
    POL_RESET = 2'd2
  } forbid_policy_t;

  // Sampled input code, packed as {S, R}; both inputs are active-low.
  typedef enum logic [1:0] {
    CODE_FORBID = 2'b00,
    CODE_SET    = 2'b01,
    CODE_RESET  = 2'b10,
    CODE_HOLD   = 2'b11
  } sr_code_t;

  localparam logic Q_RST_VAL       = 1'b0;
  localparam logic SYNC_RST_VAL    = 1'b1;
  localparam logic INVALID_RST_VAL = 1'b0;
  localparam logic ERR_RST_VAL     = 1'b0;

  // Next latch state for a forbidden sample under the chosen policy.
  function automatic logic forbid_next_q(input forbid_policy_t pol, input logic q_cur);
    case (pol)
      POL_SET:   return 1'b1;
      POL_RESET: return 1'b0;
      default:   return q_cur;
    endcase
  endfunction

endpackage

// File: rtl/sr_sync.sv
// Flop chain synchronizer; resets to the inactive (high) level of an active-low request.
module sr_sync
  import sr_latch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain;

  // Shift the input through DEPTH flops; reset flushes anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {DEPTH{SYNC_RST_VAL}};
    end else begin
      chain[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[DEPTH-1];

endmodule

// File: rtl/sr_latch.sv
// Clocked SR latch with active-low S/R, optional input synchronizers,
// a configurable response to the forbidden code, and invalid/err flags.
module sr_latch
  import sr_latch_pkg::*;
#(
  parameter int             SYNC_STAGES   = 0,
  parameter forbid_policy_t FORBID_POLICY = POL_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic S,
  input  logic R,
  input  logic clr_err,
  output logic Q,
  output logic Qbar,
  output logic invalid,
  output logic err
);

  logic s_smp;
  logic r_smp;
  logic q_r;
  logic qbar_r;
  logic invalid_r;
  logic err_r;
  logic q_next;
  logic forbidden;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      sr_sync #(.DEPTH(SYNC_STAGES)) u_sync_s (
        .clk (clk),
        .rst (rst),
        .d   (S),
        .q   (s_smp)
      );
      sr_sync #(.DEPTH(SYNC_STAGES)) u_sync_r (
        .clk (clk),
        .rst (rst),
        .d   (R),
        .q   (r_smp)
      );
    end else begin : g_direct
      assign s_smp = S;
      assign r_smp = R;
    end
  endgenerate

  // Decode the sampled request pair into the next latch state.
  always_comb begin
    q_next    = q_r;
    forbidden = 1'b0;
    case (sr_code_t'({s_smp, r_smp}))
      CODE_SET:   q_next = 1'b1;
      CODE_RESET: q_next = 1'b0;
      CODE_HOLD:  q_next = q_r;
      default: begin
        forbidden = 1'b1;
        q_next    = forbid_next_q(FORBID_POLICY, q_r);
      end
    endcase
  end

  // State flop plus a complement flop fed from the same next value, so Q and
  // Qbar move on the same edge and can never be equal; err is sticky with set
  // taking priority over clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r       <= Q_RST_VAL;
      qbar_r    <= ~Q_RST_VAL;
      invalid_r <= INVALID_RST_VAL;
      err_r     <= ERR_RST_VAL;
    end else begin
      q_r       <= q_next;
      qbar_r    <= ~q_next;
      invalid_r <= forbidden;
      err_r     <= forbidden | (err_r & ~clr_err);
    end
  end

  assign Q       = q_r;
  assign Qbar    = qbar_r;
  assign invalid = invalid_r;
  assign err     = err_r;

endmodule

// File: tb/tb_sr_latch.sv
// Scoreboard bench for sr_latch: four instances (hold/set/reset policy with
// direct sampling, hold policy with a 2-flop synchronizer) share one stimulus.
module tb_sr_latch;
  import sr_latch_pkg::*;

  logic clk = 1'b0;
  logic rst, S, R, clr_err;
  logic [3:0] q, qbar, inv, err;

  always #5 clk = ~clk;

  sr_latch #(.SYNC_STAGES(0), .FORBID_POLICY(POL_HOLD)) u_hold (
    .clk(clk), .rst(rst), .S(S), .R(R), .clr_err(clr_err),
    .Q(q[0]), .Qbar(qbar[0]), .invalid(inv[0]), .err(err[0]));
  sr_latch #(.SYNC_STAGES(0), .FORBID_POLICY(POL_SET)) u_set (
    .clk(clk), .rst(rst), .S(S), .R(R), .clr_err(clr_err),
    .Q(q[1]), .Qbar(qbar[1]), .invalid(inv[1]), .err(err[1]));
  sr_latch #(.SYNC_STAGES(0), .FORBID_POLICY(POL_RESET)) u_reset (
    .clk(clk), .rst(rst), .S(S), .R(R), .clr_err(clr_err),
    .Q(q[2]), .Qbar(qbar[2]), .invalid(inv[2]), .err(err[2]));
  sr_latch #(.SYNC_STAGES(2), .FORBID_POLICY(POL_HOLD)) u_sync2 (
    .clk(clk), .rst(rst), .S(S), .R(R), .clr_err(clr_err),
    .Q(q[3]), .Qbar(qbar[3]), .invalid(inv[3]), .err(err[3]));

  typedef struct {
    int         inst;
    logic [3:0] exp;   // {Q, Qbar, invalid, err}
    string      tag;
  } sb_t;

  sb_t sb[$];
  int  n_vec  = 0;
  int  n_miss = 0;

  // Behavioural reference: latch value and sticky error per instance, plus the
  // two-deep input delay seen by the synchronized instance.
  logic m_q[4];
  logic m_err[4];
  logic m_s1, m_s2, m_r1, m_r2;

  function automatic logic [3:0] obs(input int i);
    return {q[i], qbar[i], inv[i], err[i]};
  endfunction

  // Drive one cycle of stimulus, push the expected post-edge outputs of every
  // instance, then advance to just after the rising edge.
  task automatic step(input logic rst_i, input logic s_i, input logic r_i,
                      input logic c_i, input string tag);
    logic es, er, forb;
    @(negedge clk);
    rst = rst_i; S = s_i; R = r_i; clr_err = c_i;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin es = m_s2; er = m_r2; end
      else        begin es = s_i;  er = r_i;  end
      forb = !es && !er;
      if (rst_i) begin
        m_q[i] = 1'b0; m_err[i] = 1'b0; forb = 1'b0;
      end else begin
        if (!es && er)      m_q[i] = 1'b1;
        else if (es && !er) m_q[i] = 1'b0;
        else if (forb) begin
          if (i == 1)      m_q[i] = 1'b1;
          else if (i == 2) m_q[i] = 1'b0;
        end
        m_err[i] = forb || (m_err[i] && !c_i);
      end
      sb.push_back('{i, {m_q[i], !m_q[i], forb, m_err[i]}, tag});
    end
    if (rst_i) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_r1 = 1'b1; m_r2 = 1'b1;
    end else begin
      m_s2 = m_s1; m_s1 = s_i; m_r2 = m_r1; m_r1 = r_i;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sb_t e;
    for (int k = 0; k < 4; k++) begin
      if (k < 2) step(1'b1, 1'b1, 1'b1, 1'b0, "reset");
      else       step(1'b0, 1'b1, 1'b1, 1'b0, "post_reset_idle");
      while (sb.size() > 0) begin
        e = sb.pop_front(); n_vec++;
        if (obs(e.inst) !== e.exp) begin
          n_miss++;
          $display("FAIL %s inst%0d {Q,Qbar,invalid,err} got %b want %b", e.tag, e.inst, obs(e.inst), e.exp);
        end
      end
    end
  endtask

  task automatic test_set_reset_seq();
    sb_t e;
    logic [1:0] codes [5] = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b11};
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < 5; k++) begin
        step(1'b0, codes[c][1], codes[c][0], 1'b0, "sr_sequence");
        while (sb.size() > 0) begin
          e = sb.pop_front(); n_vec++;
          if (obs(e.inst) !== e.exp) begin
            n_miss++;
            $display("FAIL %s inst%0d {Q,Qbar,invalid,err} got %b want %b", e.tag, e.inst, obs(e.inst), e.exp);
          end
        end
      end
    end
  endtask

  task automatic test_forbid_hold();
    sb_t e;
    // {S, R, clr_err}: set Q, one forbidden sample, idle, clear, idle
    logic [2:0] vec [12] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b110,
                             3'b110, 3'b110, 3'b110, 3'b111, 3'b110, 3'b110};
    for (int k = 0; k < 12; k++) begin
      step(1'b0, vec[k][2], vec[k][1], vec[k][0], "forbid_hold");
      while (sb.size() > 0) begin
        e = sb.pop_front(); n_vec++;
        if (obs(e.inst) !== e.exp) begin
          n_miss++;
          $display("FAIL %s inst%0d {Q,Qbar,invalid,err} got %b want %b", e.tag, e.inst, obs(e.inst), e.exp);
        end
      end
    end
  endtask

  task automatic test_policy();
    sb_t e;
    // From Q=0 then from Q=1, hit the forbidden code; clear err in between.
    logic [2:0] vec [14] = '{3'b100, 3'b100, 3'b100, 3'b000, 3'b111, 3'b111, 3'b111,
                             3'b010, 3'b010, 3'b010, 3'b000, 3'b110, 3'b110, 3'b111};
    for (int k = 0; k < 14; k++) begin
      step(1'b0, vec[k][2], vec[k][1], vec[k][0], "forbid_policy");
      while (sb.size() > 0) begin
        e = sb.pop_front(); n_vec++;
        if (obs(e.inst) !== e.exp) begin
          n_miss++;
          $display("FAIL %s inst%0d {Q,Qbar,invalid,err} got %b want %b", e.tag, e.inst, obs(e.inst), e.exp);
        end
      end
    end
  endtask

  task automatic test_clr_collide();
    sb_t e;
    logic [2:0] vec [9] = '{3'b111, 3'b111, 3'b111, 3'b001, 3'b111,
                            3'b111, 3'b111, 3'b111, 3'b110};
    for (int k = 0; k < 9; k++) begin
      step(1'b0, vec[k][2], vec[k][1], vec[k][0], "clr_vs_forbid");
      while (sb.size() > 0) begin
        e = sb.pop_front(); n_vec++;
        if (obs(e.inst) !== e.exp) begin
          n_miss++;
          $display("FAIL %s inst%0d {Q,Qbar,invalid,err} got %b want %b", e.tag, e.inst, obs(e.inst), e.exp);
        end
      end
    end
  endtask

  task automatic test_sync_latency();
    sb_t e;
    // rst, rst, S pulse, then idle; synchronized Q must rise on the 3rd edge.
    logic [1:0] vec [8] = '{2'b11, 2'b11, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    logic exp_q3 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 8; k++) begin
      step(vec[k][1], vec[k][0], 1'b1, 1'b0, "sync_latency");
      while (sb.size() > 0) begin
        e = sb.pop_front(); n_vec++;
        if (obs(e.inst) !== e.exp) begin
          n_miss++;
          $display("FAIL %s inst%0d {Q,Qbar,invalid,err} got %b want %b", e.tag, e.inst, obs(e.inst), e.exp);
        end
      end
      n_vec++;
      if (q[3] !== exp_q3[k]) begin
        n_miss++;
        $display("FAIL sync_latency_q cycle%0d Q got %b want %b", k, q[3], exp_q3[k]);
      end
    end
  endtask

  task automatic test_sync_reset_flush();
    sb_t e;
    // rst, S pulse, rst while the pulse is inside the synchronizer, then idle.
    logic [1:0] vec [8] = '{2'b11, 2'b00, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    for (int k = 0; k < 8; k++) begin
      step(vec[k][1], vec[k][0], 1'b1, 1'b0, "sync_rst_flush");
      while (sb.size() > 0) begin
        e = sb.pop_front(); n_vec++;
        if (obs(e.inst) !== e.exp) begin
          n_miss++;
          $display("FAIL %s inst%0d {Q,Qbar,invalid,err} got %b want %b", e.tag, e.inst, obs(e.inst), e.exp);
        end
      end
      n_vec++;
      if (q[3] !== 1'b0) begin
        n_miss++;
        $display("FAIL sync_rst_flush_q cycle%0d Q got %b want 0", k, q[3]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; S = 1'b1; R = 1'b1; clr_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_q[i] = 1'b0; m_err[i] = 1'b0;
    end
    m_s1 = 1'b1; m_s2 = 1'b1; m_r1 = 1'b1; m_r2 = 1'b1;
    test_reset();
    test_set_reset_seq();
    test_forbid_hold();
    test_policy();
    test_clr_collide();
    test_sync_latency();
    test_sync_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
